// File: rtl/perf_counter_arbiter.sv
// Round-robin owner of one shared performance counter: grant, clear, run, capture, report.
// Define PERF_ARB_WATCHDOG_EN to build the RUN watchdog (TIMEOUT_CYCLES); otherwise res_timeout is 0.
module perf_counter_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int CNT_WIDTH      = 64,
  parameter int ID_W           = $clog2(NUM_REQ),
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  input  logic [NUM_REQ-1:0]   req,
  input  logic [NUM_REQ-1:0]   stop,
  output logic [NUM_REQ-1:0]   gnt,
  output logic                 cnt_clr,
  output logic                 cnt_en,
  input  logic [CNT_WIDTH-1:0] cnt_q,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [CNT_WIDTH-1:0] res_data,
  output logic [ID_W-1:0]      res_id,
  output logic                 res_timeout,
  output logic                 busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_HOLD,
    S_RESULT
  } state_t;

  state_t               state_reg, state_next;
  logic [NUM_REQ-1:0]   gnt_reg;
  logic [ID_W-1:0]      last_reg;
  logic [CNT_WIDTH-1:0] res_data_reg;
  logic [ID_W-1:0]      res_id_reg;
  logic                 res_timeout_reg;

  logic                 win_found;
  logic [ID_W-1:0]      win_idx;
  logic [ID_W:0]        cand;
  logic [NUM_REQ-1:0]   win_onehot;
  logic                 owner_req;
  logic                 owner_stop;
  logic                 wd_hit;
  logic                 timeout_flag;

  // Scan from last+1 upward, wrapping, so the previous owner is considered last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_reg;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, last_reg} + (ID_W+1)'(k + 1);
      if (cand >= (ID_W+1)'(NUM_REQ)) begin
        cand = cand - (ID_W+1)'(NUM_REQ);
      end
      if (!win_found && req[cand[ID_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[ID_W-1:0];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_onehot
      assign win_onehot[gi] = (win_idx == ID_W'(gi));
    end
  endgenerate

  assign owner_req  = |(req & gnt_reg);
  assign owner_stop = |(stop & gnt_reg);

`ifdef PERF_ARB_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] run_cnt_reg;
  logic            timeout_flag_reg;

  // run_cnt_reg holds the 1-based index of the current RUN cycle.
  assign wd_hit       = (run_cnt_reg == WD_W'(TIMEOUT_CYCLES));
  assign timeout_flag = timeout_flag_reg;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_cnt_reg      <= '0;
      timeout_flag_reg <= 1'b0;
    end else if (state_reg == S_CLEAR) begin
      run_cnt_reg      <= WD_W'(1);
      timeout_flag_reg <= 1'b0;
    end else if (state_reg == S_RUN) begin
      run_cnt_reg      <= run_cnt_reg + 1'b1;
      timeout_flag_reg <= wd_hit && !owner_stop;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg   = (TIMEOUT_CYCLES > 0);
  assign wd_hit       = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Control outputs are pure decodes of state_reg.
  always_comb begin
    state_next = state_reg;
    cnt_clr    = 1'b0;
    cnt_en     = 1'b0;
    res_valid  = 1'b0;
    busy       = 1'b1;
    case (state_reg)
      S_IDLE: begin
        busy = 1'b0;
        if (win_found) state_next = S_CLEAR;
      end
      S_CLEAR: begin
        cnt_clr    = 1'b1;
        state_next = S_RUN;
      end
      S_RUN: begin
        cnt_en = 1'b1;
        if (!owner_req) begin
          state_next = S_IDLE;
        end else if (owner_stop || wd_hit) begin
          state_next = S_HOLD;
        end
      end
      S_HOLD: begin
        state_next = S_RESULT;
      end
      S_RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_next = S_IDLE;
      end
      default: begin
        busy       = 1'b0;
        state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      gnt_reg         <= '0;
      last_reg        <= ID_W'(NUM_REQ - 1);
      res_data_reg    <= '0;
      res_id_reg      <= '0;
      res_timeout_reg <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (win_found) begin
            gnt_reg  <= win_onehot;
            last_reg <= win_idx;
          end
        end
        S_RUN: begin
          if (!owner_req) gnt_reg <= '0;
        end
        S_HOLD: begin
          res_data_reg    <= cnt_q;
          res_id_reg      <= last_reg;
          res_timeout_reg <= timeout_flag;
        end
        S_RESULT: begin
          if (res_ready) gnt_reg <= '0;
        end
        default: ;
      endcase
    end
  end

  assign gnt         = gnt_reg;
  assign res_data    = res_data_reg;
  assign res_id      = res_id_reg;
  assign res_timeout = res_timeout_reg;

endmodule

// File: tb/tb_perf_counter_arbiter.sv
// Scoreboard bench for perf_counter_arbiter with a behavioural 64-bit counter attached.
// Define PERF_ARB_WATCHDOG_EN to exercise the watchdog (TIMEOUT_CYCLES=20).
module tb_perf_counter_arbiter;

  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 64;
  localparam int ID_W    = 2;
  localparam int TO      = 20;

  logic             aclk = 1'b0;
  logic             aresetn = 1'b0;
  logic [3:0]       req = '0;
  logic [3:0]       stop = '0;
  logic [3:0]       gnt;
  logic             cnt_clr;
  logic             cnt_en;
  logic [CNT_W-1:0] cnt_q = '0;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [CNT_W-1:0] res_data;
  logic [ID_W-1:0]  res_id;
  logic             res_timeout;
  logic             busy;

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  id;
    logic        to;
  } res_t;

  res_t exp_q[$];
  int   pass_cnt  = 0;
  int   total_cnt = 0;

  perf_counter_arbiter #(
    .NUM_REQ(NUM_REQ),
    .CNT_WIDTH(CNT_W),
    .ID_W(ID_W),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .req(req),
    .stop(stop),
    .gnt(gnt),
    .cnt_clr(cnt_clr),
    .cnt_en(cnt_en),
    .cnt_q(cnt_q),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_data(res_data),
    .res_id(res_id),
    .res_timeout(res_timeout),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  // External counter: synchronous clear has priority over enable.
  always_ff @(posedge aclk) begin
    if (cnt_clr) cnt_q <= '0;
    else if (cnt_en) cnt_q <= cnt_q + 64'd1;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic push_exp(input int n, input int id, input logic to);
    res_t e;
    e.data = 64'(n);
    e.id   = 2'(id);
    e.to   = to;
    exp_q.push_back(e);
  endtask

  task automatic check_reset();
    check("rst_gnt", 64'(gnt), 64'd0);
    check("rst_cnt_clr", 64'(cnt_clr), 64'd0);
    check("rst_cnt_en", 64'(cnt_en), 64'd0);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_res_data", res_data, 64'd0);
    check("rst_res_id", 64'(res_id), 64'd0);
    check("rst_res_timeout", 64'(res_timeout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
  endtask

  // From IDLE with req already driven, the grant must arrive after exactly one edge.
  task automatic wait_gnt(input int id);
    int c = 0;
    while (gnt == 4'b0000 && c < 20) begin
      tick();
      c++;
    end
    check("grant_latency", 64'(c), 64'd1);
    check("gnt_onehot", 64'(gnt), 64'(4'b0001 << id));
    check("cnt_clr_on", 64'(cnt_clr), 64'd1);
  endtask

  task automatic wait_idle(input int max);
    int c = 0;
    while (busy && c < max) begin
      tick();
      c++;
    end
    check("return_to_idle", 64'(busy), 64'd0);
  endtask

  // Runs one owner for n RUN cycles, then stops it; optionally drops req while in HOLD.
  task automatic session(input int id, input int n, input bit drop);
    wait_gnt(id);
    tick();
    check("cnt_clr_one_cycle", 64'(cnt_clr), 64'd0);
    check("cnt_en_run", 64'(cnt_en), 64'd1);
    repeat (n - 1) tick();
    stop = 4'b0001 << id;
    push_exp(n, id, 1'b0);
    tick();
    stop = '0;
    if (drop) req = '0;
    check("cnt_en_hold", 64'(cnt_en), 64'd0);
    wait_idle(20);
  endtask

  // Monitor: every completed handshake consumes one scoreboard entry.
  initial begin
    res_t e;
    forever begin
      @(negedge aclk);
      if (aresetn && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_result", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("res_data", res_data, e.data);
          check("res_id", 64'(res_id), 64'(e.id));
          check("res_timeout", 64'(res_timeout), 64'(e.to));
          $display("result id=%0d data=%0d timeout=%0d", res_id, res_data, res_timeout);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    #12;
    check_reset();
    #8 aresetn = 1'b1;
    tick();

    // Round-robin with all requesters held: 0,1,2,3 then wrap to 0.
    req = 4'b1111;
    session(0, 3, 1'b0);
    session(1, 5, 1'b0);
    session(2, 1, 1'b0);
    session(3, 7, 1'b0);
    session(0, 2, 1'b1);

    // Single session, stop on the 10th RUN cycle.
    req = 4'b0001;
    session(0, 10, 1'b1);
    check("res_data_held", res_data, 64'd10);

    // Foreign stop ignored, then owner abort.
    req = 4'b0100;
    wait_gnt(2);
    tick();
    repeat (3) tick();
    stop = 4'b0010;
    tick();
    stop = '0;
    check("foreign_stop_cnt_en", 64'(cnt_en), 64'd1);
    check("foreign_stop_busy", 64'(busy), 64'd1);
    repeat (2) tick();
    req = '0;
    tick();
    check("abort_gnt", 64'(gnt), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_cnt_en", 64'(cnt_en), 64'd0);
    repeat (3) begin
      tick();
      check("abort_no_valid", 64'(res_valid), 64'd0);
    end

    // Abort and owner stop in the same cycle: abort wins.
    req = 4'b0100;
    wait_gnt(2);
    tick();
    repeat (2) tick();
    req  = '0;
    stop = 4'b0100;
    tick();
    stop = '0;
    check("abort_stop_gnt", 64'(gnt), 64'd0);
    check("abort_stop_busy", 64'(busy), 64'd0);
    tick();
    check("abort_stop_no_valid", 64'(res_valid), 64'd0);

    // Result backpressure for 5 cycles.
    res_ready = 1'b0;
    req = 4'b0010;
    wait_gnt(1);
    tick();
    repeat (3) tick();
    stop = 4'b0010;
    push_exp(4, 1, 1'b0);
    tick();
    stop = '0;
    req  = '0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 64'(res_valid), 64'd1);
      check("bp_data", res_data, 64'd4);
      check("bp_gnt", 64'(gnt), 64'd2);
      tick();
    end
    res_ready = 1'b1;
    tick();
    check("bp_done_valid", 64'(res_valid), 64'd0);
    check("bp_done_gnt", 64'(gnt), 64'd0);
    repeat (3) tick();

    // Asynchronous reset in the middle of RUN.
    req = 4'b0001;
    wait_gnt(0);
    tick();
    repeat (4) tick();
    #3 aresetn = 1'b0;
    #1 check_reset();
    req = 4'b1000;
    #2 aresetn = 1'b1;
    session(3, 2, 1'b1);

`ifdef PERF_ARB_WATCHDOG_EN
    // Watchdog forces HOLD after TO RUN cycles.
    req = 4'b0001;
    wait_gnt(0);
    push_exp(TO, 0, 1'b1);
    repeat (TO) tick();
    check("wd_last_run_cycle", 64'(cnt_en), 64'd1);
    tick();
    check("wd_hold", 64'(cnt_en), 64'd0);
    req = '0;
    wait_idle(20);
    // A real stop on the timeout cycle wins.
    req = 4'b0001;
    session(0, TO, 1'b1);
`else
    // Without the watchdog, RUN is unbounded.
    req = 4'b0001;
    wait_gnt(0);
    tick();
    repeat (100) tick();
    check("no_wd_cnt_en", 64'(cnt_en), 64'd1);
    check("no_wd_busy", 64'(busy), 64'd1);
    req = '0;
    tick();
    check("no_wd_abort_idle", 64'(busy), 64'd0);
`endif

    repeat (3) tick();
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
